shifter_pipe: RTL and testbench
===============================

# shifter_pipe

Parametrised, pipelined barrel shifter with valid/ready handshake; the successor of the fixed registered shift-left-by-2 used for branch/jump offset scaling. Supports logical left, logical right and arithmetic right shifts by a run-time amount, spread across a configurable number of register stages. It sits beside the ALU in the execute path and also serves as the branch-offset scaler when driven with a constant shift amount of 2.

## Interface
- WIDTH, 32: data width; power of two, 8..64.
- STAGES, 2: pipeline register stages, 1..log2(WIDTH); derived SHAMT_W = log2(WIDTH).
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block accepts operand this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL (see Configuration).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_mode  output  2  mode that produced out_data.

## Operation
- Shift decomposed into SHAMT_W barrel levels; level k shifts by 2^k when shamt bit k set.
- Levels assigned to stages in order, ceil(SHAMT_W/STAGES) per stage, earlier stages take extra levels; each stage registers valid, data, mode and remaining shamt bits.
- SLL fills zeros from bit 0; SRL fills zeros from MSB; SRA fills with in_data[WIDTH-1] captured at accept.
- shamt 0 returns in_data unchanged in every mode.
- Transfer occurs on valid && ready at each boundary; data held stable while valid && !ready.
- Stage s advances when stage s+1 is empty or advancing; last stage advances on out_ready. Bubbles collapse.
- in_ready = !stage0_valid || stage0_advance (combinational path from out_ready allowed).
- Results emerge in acceptance order; no reordering, no drops.

## Timing
- Latency: accept at edge N -> out_valid high after edge N+STAGES-1 (STAGES=1: one cycle; STAGES=2: result valid the cycle after the registering edge of stage 0 plus one).
- Throughput: one result per cycle with out_ready held high.
- Reset (asynchronous, any time, including mid-stream): all stage valids 0, data/shamt/mode registers 0; out_valid 0, out_data 0, out_mode 0. in_ready is 0 while reset is high and 1 on the first cycle after release. In-flight operands are discarded.
- Simultaneous accept and emit with a full pipeline is legal and keeps occupancy constant.

## Configuration
- SHIFTER_ROTATE_EN defined: mode 11 = rotate left; bits shifted out of the MSB re-enter at bit 0.
- Undefined: mode 11 decodes as SLL; out_mode still reports 11. No rotate muxing is synthesised.

## Structure
- Package shifter_pkg: mode localparams (MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROTL), typedef for the 2-bit mode, function computing levels per stage.
- One sub-module, shifter_stage: applies a contiguous range of barrel levels and holds one pipeline register with its valid/ready handshake. shifter_pipe instantiates STAGES of them in a generate loop.

## Test plan
- WIDTH=32, STAGES=2, SLL, in_data=0x0000_0001, shamt=2, out_ready=1 -> out_data=0x0000_0004 after the specified latency; shamt=31 -> 0x8000_0000.
- SRA in_data=0x8000_00F0, shamt=4 -> 0xF800_000F; SRL same operand -> 0x0800_000F.
- Back-to-back stream of 16 operands, out_ready=1 -> 16 results in order, one per cycle, no gaps.
- out_ready held 0 for 5 cycles mid-stream -> out_data/out_valid stable, in_ready drops once both stages are full, no loss, order preserved after release.
- Mode 11, in_data=0x8000_0001, shamt=1 -> 0x0000_0003 with SHIFTER_ROTATE_EN defined, 0x0000_0002 without.
- Assert reset with 2 operands in flight -> out_valid, out_data 0 immediately (asynchronous); after release the next operand produces a correct result with no stale output.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   mode_t              2-bit shift mode
//   MODE_*              mode encodings (SLL, SRL, SRA, ROTL)
//   levels_per_stage()  barrel levels handled by each pipeline stage
//   stage_first_level() first barrel level owned by a stage
//   stage_end_level()   one past the last barrel level owned by a stage
package shifter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SLL  = 2'b00;
    localparam mode_t MODE_SRL  = 2'b01;
    localparam mode_t MODE_SRA  = 2'b10;
    localparam mode_t MODE_ROTL = 2'b11;

    // Ceiling division, so earlier stages absorb any leftover levels.
    function automatic int levels_per_stage(input int shamt_w, input int stages);
        return (shamt_w + stages - 1) / stages;
    endfunction

    // Clamped to shamt_w: trailing stages may own no levels at all and
    // then act as plain pipeline registers.
    function automatic int stage_first_level(input int s, input int shamt_w, input int stages);
        int lo;
        lo = s * levels_per_stage(shamt_w, stages);
        return (lo > shamt_w) ? shamt_w : lo;
    endfunction

    function automatic int stage_end_level(input int s, input int shamt_w, input int stages);
        return stage_first_level(s + 1, shamt_w, stages);
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline stage of the barrel shifter: applies barrel levels
// [LVL_LO, LVL_HI) combinationally to its input, then registers the result
// together with valid, mode and the shift-amount bits still to be applied.
// Optional feature: SHIFTER_ROTATE_EN enables rotate-left for mode 11;
// without it mode 11 shifts like SLL.
// Ports:
//   clock, reset            clock, asynchronous active-high reset
//   in_valid / in_ready     upstream handshake
//   in_data, in_shamt,      operand, remaining shift amount, mode
//   in_mode
//   out_valid / out_ready   downstream handshake
//   out_data, out_shamt,    registered partial result, remaining shamt,
//   out_mode                mode
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int LVL_LO  = 0,
    parameter int LVL_HI  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  mode_t              in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output mode_t              out_mode
);

    localparam int NLVL = LVL_HI - LVL_LO;

    // level_data[i] is the operand after the first i levels of this stage.
    logic [NLVL:0][WIDTH-1:0] level_data;
    logic [SHAMT_W-1:0]       done_mask;

    logic               valid_reg;
    logic [WIDTH-1:0]   data_reg;
    logic [SHAMT_W-1:0] shamt_reg;
    mode_t              mode_reg;

    assign level_data[0] = in_data;

    genvar gi;
    generate
        for (gi = 0; gi < NLVL; gi++) begin : g_level
            localparam int K   = LVL_LO + gi;
            localparam int AMT = 1 << K;
            logic [WIDTH-1:0] shifted;

            // Arithmetic right shift level by level keeps the MSB, so the
            // sign captured at accept propagates through every stage.
            always_comb begin
                shifted = level_data[gi];
                if (in_shamt[K]) begin
                    case (in_mode)
                        MODE_SRL: shifted = level_data[gi] >> AMT;
                        MODE_SRA: shifted = $signed(level_data[gi]) >>> AMT;
`ifdef SHIFTER_ROTATE_EN
                        MODE_ROTL: shifted = (level_data[gi] << AMT) |
                                             (level_data[gi] >> (WIDTH - AMT));
`endif
                        default:  shifted = level_data[gi] << AMT;
                    endcase
                end
            end

            assign level_data[gi+1] = shifted;
        end

        // Bits consumed here are cleared before being passed on.
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_mask
            assign done_mask[gi] = (gi >= LVL_LO) && (gi < LVL_HI);
        end
    endgenerate

    assign in_ready = !valid_reg || out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            shamt_reg <= '0;
            mode_reg  <= MODE_SLL;
        end else if (in_ready) begin
            // Loading a bubble empties the stage, so gaps collapse.
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg  <= level_data[NLVL];
                shamt_reg <= in_shamt & ~done_mask;
                mode_reg  <= in_mode;
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_shamt = shamt_reg;
    assign out_mode  = mode_reg;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL / SRL / SRA / optional ROTL) with
// valid/ready handshake on both sides. The log2(WIDTH) barrel levels are
// spread over STAGES register stages, earlier stages taking extra levels.
// Optional feature: define SHIFTER_ROTATE_EN to make mode 11 a rotate-left;
// otherwise mode 11 shifts like SLL while out_mode still reports 11.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   operand present          in_ready   operand accepted
//   in_data    operand                  in_shamt   shift amount 0..WIDTH-1
//   in_mode    00 SLL, 01 SRL, 10 SRA, 11 ROTL
//   out_valid  result present           out_ready  consumer accepts
//   out_data   shifted result           out_mode   mode of out_data
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 2,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_mode
);

    // Index s is the input side of stage s; index STAGES is the pipe output.
    logic [STAGES:0]                valid_c;
    logic [STAGES:0]                ready_c;
    logic [STAGES:0][WIDTH-1:0]     data_c;
    logic [STAGES:0][SHAMT_W-1:0]   shamt_c;
    logic [STAGES:0][1:0]           mode_c;
    logic [SHAMT_W-1:0]             unused_shamt;

    assign valid_c[0] = in_valid;
    assign data_c[0]  = in_data;
    assign shamt_c[0] = in_shamt;
    assign mode_c[0]  = in_mode;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            shifter_stage #(
                .WIDTH   (WIDTH),
                .SHAMT_W (SHAMT_W),
                .LVL_LO  (stage_first_level(gi, SHAMT_W, STAGES)),
                .LVL_HI  (stage_end_level(gi, SHAMT_W, STAGES))
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .in_valid  (valid_c[gi]),
                .in_ready  (ready_c[gi]),
                .in_data   (data_c[gi]),
                .in_shamt  (shamt_c[gi]),
                .in_mode   (mode_c[gi]),
                .out_valid (valid_c[gi+1]),
                .out_ready (ready_c[gi+1]),
                .out_data  (data_c[gi+1]),
                .out_shamt (shamt_c[gi+1]),
                .out_mode  (mode_c[gi+1])
            );
        end
    endgenerate

    assign ready_c[STAGES] = out_ready;

    // Every level has been applied by the last stage, so this is all zero.
    assign unused_shamt = shamt_c[STAGES];

    // Stage 0 already reports ready when empty; masking with reset keeps
    // the block from accepting while it is being cleared.
    assign in_ready  = ready_c[0] && !reset;
    assign out_valid = valid_c[STAGES];
    assign out_data  = data_c[STAGES];
    assign out_mode  = mode_c[STAGES];

endmodule

// File: tb/tb_shifter_pipe.sv
module tb_shifter_pipe;

    localparam int WIDTH   = 32;
    localparam int STAGES  = 2;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] M_SLL  = 2'b00;
    localparam logic [1:0] M_SRL  = 2'b01;
    localparam logic [1:0] M_SRA  = 2'b10;
    localparam logic [1:0] M_ROTL = 2'b11;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [31:0] ROTL_EXP = 32'h0000_0003;
`else
    localparam logic [31:0] ROTL_EXP = 32'h0000_0002;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_mode;

    always #5 clock = ~clock;

    shifter_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mode;
    } exp_t;

    exp_t sb[$];
    int   out_cycles[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever
    // out_valid && out_ready hold at the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%08h expected none", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("result data=0x%08h mode=%0d (expect 0x%08h mode=%0d)",
                             out_data, out_mode, e.data, e.mode);
                    check("result_data", out_data, e.data);
                    check("result_mode", {30'b0, out_mode}, {30'b0, e.mode});
                    out_cycles.push_back(cyc);
                end
            end
        end
    end

    // Present one operand; the expectation is queued at the falling edge
    // preceding the accepting rising edge. Returns at that falling edge.
    task automatic send(input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] m, input logic [31:0] exp_data);
        bit done;
        done = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back('{exp_data, m});
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for operand 0x%08h", d);
        end
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = M_SLL;
        out_ready = 1'b1;

        // Reset state
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_mode", {30'b0, out_mode}, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("in_ready_after_release", in_ready, 1);

        // Latency: accept at edge N, out_valid after edge N+STAGES-1
        send(32'h0000_0001, 5'd2, M_SLL, 32'h0000_0004);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check("latency_not_early", out_valid, 0);
        @(negedge clock);
        check("latency_valid", out_valid, 1);
        check("latency_data", out_data, 32'h0000_0004);

        // Directed vectors
        send(32'h0000_0001, 5'd31, M_SLL,  32'h8000_0000);
        send(32'h8000_00F0, 5'd4,  M_SRA,  32'hF800_000F);
        send(32'h8000_00F0, 5'd4,  M_SRL,  32'h0800_000F);
        send(32'h8000_0001, 5'd0,  M_SRA,  32'h8000_0001);
        send(32'h7000_0000, 5'd28, M_SRA,  32'h0000_0007);
        send(32'hFFFF_FFFF, 5'd31, M_SRL,  32'h0000_0001);
        send(32'h8000_0001, 5'd1,  M_ROTL, ROTL_EXP);
        send(32'h1234_5678, 5'd0,  M_ROTL, 32'h1234_5678);
        idle();
        drain();

        // Back-to-back stream of 16
        base = out_cycles.size();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) send(32'h0000_0001, 5'(i), M_SLL, 32'h0000_0001 << i);
            else            send(32'h8000_0000, 5'(i), M_SRL, 32'h8000_0000 >> i);
        end
        idle();
        drain();
        check("stream_count", out_cycles.size() - base, 16);
        if (out_cycles.size() >= base + 16)
            check("stream_no_gaps", out_cycles[base+15] - out_cycles[base], 15);

        // Back-pressure for 5 cycles
        @(posedge clock);
        #1 out_ready = 1'b0;
        send(32'hF000_0000, 5'd8, M_SRA, 32'hFFF0_0000);
        send(32'h0000_00FF, 5'd4, M_SLL, 32'h0000_0FF0);
        fork
            send(32'hFFFF_FFFF, 5'd31, M_SRL, 32'h0000_0001);
            begin
                @(posedge clock);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clock);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_out_data", out_data, 32'hFFF0_0000);
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Asynchronous reset with operands in flight
        @(posedge clock);
        #1 out_ready = 1'b0;
        send(32'h0000_0011, 5'd1, M_SLL, 32'h0000_0022);
        send(32'h0000_0022, 5'd1, M_SLL, 32'h0000_0044);
        @(posedge clock);
        #1 in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_out_data", out_data, 0);
        check("async_reset_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_reset_in_ready", in_ready, 1);
        send(32'h0000_0003, 5'd3, M_SLL, 32'h0000_0018);
        check("post_reset_no_stale", out_valid, 0);
        idle();
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
